// File: rtl/clock_seq_scan.sv
// Time-of-day sequencer with a four-digit multiplexed display scan.
// Time is held as 24-hour BCD; the 12-hour view exists only on the display path.
module clock_seq_scan #(
  parameter int SCAN_DIV         = 4,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       SyncMinIn,
  input  logic       SyncHourIn,
  input  logic       Mode12,
  input  logic       Blank,
  output logic [3:0] Digit,
  output logic [3:0] D,
  output logic       DP,
  output logic       PM,
  output logic [3:0] min1,
  output logic [2:0] min10,
  output logic [3:0] hour1,
  output logic [1:0] hour10
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);
  localparam logic [3:0] OFF = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    slot, slot_n;
  logic          colon;

  logic          sync, tick_on, min_wrap;
  logic          min_inc, hour_inc;
  logic [3:0]    min1_n, hour1_n;
  logic [2:0]    min10_n;
  logic [1:0]    hour10_n;

  logic [1:0]    dh10;
  logic [3:0]    dh1;
  logic [3:0]    digit_n, d_n;
  logic          dp_n, pm_n;

  // Any sync pulse pre-empts a same-cycle tick.
  assign sync     = SyncMinIn | SyncHourIn;
  assign tick_on  = Tick & ~sync;
  assign min_wrap = (min10 == 3'd5) && (min1 == 4'd9);
  assign min_inc  = SyncMinIn | tick_on;
  assign hour_inc = SyncHourIn | (tick_on & min_wrap);

  always_comb begin
    min1_n  = min1;
    min10_n = min10;
    if (min_inc) begin
      if (min1 == 4'd9) begin
        min1_n  = 4'd0;
        min10_n = (min10 == 3'd5) ? 3'd0 : min10 + 3'd1;
      end else begin
        min1_n  = min1 + 4'd1;
      end
    end
  end

  always_comb begin
    hour1_n  = hour1;
    hour10_n = hour10;
    if (hour_inc) begin
      if (hour10 == 2'd2 && hour1 == 4'd3) begin
        hour1_n  = 4'd0;
        hour10_n = 2'd0;
      end else if (hour1 == 4'd9) begin
        hour1_n  = 4'd0;
        hour10_n = hour10 + 2'd1;
      end else begin
        hour1_n  = hour1 + 4'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      min1   <= '0;
      min10  <= '0;
      hour1  <= '0;
      hour10 <= '0;
      colon  <= 1'b0;
    end else begin
      min1   <= min1_n;
      min10  <= min10_n;
      hour1  <= hour1_n;
      hour10 <= hour10_n;
      colon  <= colon ^ tick_on;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt  <= '0;
      slot <= 2'd0;
    end else begin
      cnt  <= cnt_n;
      slot <= slot_n;
    end
  end

  always_comb begin
    cnt_n  = cnt + 1'b1;
    slot_n = slot;
    if (cnt == TC) begin
      cnt_n  = '0;
      slot_n = slot + 2'd1;
    end
  end

  always_comb begin
    dh10 = hour10;
    dh1  = hour1;
    if (Mode12) begin
      unique case (1'b1)
        hour10 == 2'd0 && hour1 == 4'd0: begin
          dh10 = 2'd1;
          dh1  = 4'd2;
        end
        hour10 == 2'd1 && hour1 > 4'd2: begin
          dh10 = 2'd0;
          dh1  = hour1 - 4'd2;
        end
        hour10 == 2'd2 && hour1 < 4'd2: begin
          dh10 = 2'd0;
          dh1  = hour1 + 4'd8;
        end
        hour10 == 2'd2 && hour1 >= 4'd2: begin
          dh10 = 2'd1;
          dh1  = hour1 - 4'd2;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    d_n = 4'hF;
    case (slot)
      2'd0: d_n = (Mode12 && dh10 == 2'd0) ? 4'hF : {2'b00, dh10};
      2'd1: d_n = dh1;
      2'd2: d_n = {1'b0, min10};
      2'd3: d_n = min1;
    endcase
    digit_n = Blank ? 4'h0 : (4'b0001 << slot);
    if (DIGIT_ACTIVE_LOW)
      digit_n = ~digit_n;
    dp_n = (slot == 2'd1) && colon;
    pm_n = (hour10 == 2'd2) || (hour10 == 2'd1 && hour1 >= 4'd2);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Digit <= OFF;
      D     <= 4'h0;
      DP    <= 1'b0;
      PM    <= 1'b0;
    end else begin
      Digit <= digit_n;
      D     <= d_n;
      DP    <= dp_n;
      PM    <= pm_n;
    end
  end

endmodule

// File: tb/tb_clock_seq_scan.sv
// Scoreboarded random bench for clock_seq_scan.
// Two instances: SCAN_DIV=4 active-high and SCAN_DIV=3 active-low.
module tb_clock_seq_scan;

  logic clk;
  logic Reset, Tick, SyncMinIn, SyncHourIn, Mode12, Blank;

  logic [3:0] dig_a, d_a, min1_a, hour1_a;
  logic       dp_a, pm_a;
  logic [2:0] min10_a;
  logic [1:0] hour10_a;

  logic [3:0] dig_b, d_b, min1_b, hour1_b;
  logic       dp_b, pm_b;
  logic [2:0] min10_b;
  logic [1:0] hour10_b;

  clock_seq_scan #(.SCAN_DIV(4), .DIGIT_ACTIVE_LOW(1'b0)) u_a (
    .Clock(clk), .Reset(Reset), .Tick(Tick),
    .SyncMinIn(SyncMinIn), .SyncHourIn(SyncHourIn),
    .Mode12(Mode12), .Blank(Blank),
    .Digit(dig_a), .D(d_a), .DP(dp_a), .PM(pm_a),
    .min1(min1_a), .min10(min10_a),
    .hour1(hour1_a), .hour10(hour10_a)
  );

  clock_seq_scan #(.SCAN_DIV(3), .DIGIT_ACTIVE_LOW(1'b1)) u_b (
    .Clock(clk), .Reset(Reset), .Tick(Tick),
    .SyncMinIn(SyncMinIn), .SyncHourIn(SyncHourIn),
    .Mode12(Mode12), .Blank(Blank),
    .Digit(dig_b), .D(d_b), .DP(dp_b), .PM(pm_b),
    .min1(min1_b), .min10(min10_b),
    .hour1(hour1_b), .hour10(hour10_b)
  );

  typedef struct {
    logic [3:0]  dig_a, d_a, dig_b, d_b;
    logic        dp_a, dp_b, pm;
    logic [15:0] tm;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int hh = 0, mm = 0, cyc = 0;
  bit colon = 0;
  bit m12 = 0, bl = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] digit_val(int slot, bit mode12);
    int dh;
    dh = mode12 ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
    case (slot)
      0: return (mode12 && dh < 10) ? 4'hF : 4'(dh / 10);
      1: return 4'(dh % 10);
      2: return 4'(mm / 10);
      default: return 4'(mm % 10);
    endcase
  endfunction

  function automatic logic [3:0] en_val(int slot, bit blank);
    logic [3:0] one;
    one = 4'b0001;
    return blank ? 4'h0 : (one << slot);
  endfunction

  task automatic step(bit r, bit t, bit sm, bit sh, bit md, bit bk);
    exp_t e;
    int sa, sb, tot;
    @(negedge clk);
    Reset = r; Tick = t; SyncMinIn = sm; SyncHourIn = sh;
    Mode12 = md; Blank = bk;
    if (r) begin
      e.dig_a = 4'h0; e.d_a = 4'h0; e.dp_a = 1'b0;
      e.dig_b = 4'hF; e.d_b = 4'h0; e.dp_b = 1'b0;
      e.pm = 1'b0;
      hh = 0; mm = 0; colon = 0; cyc = 0;
    end else begin
      sa = (cyc / 4) % 4;
      sb = (cyc / 3) % 4;
      e.dig_a = en_val(sa, bk);
      e.d_a   = digit_val(sa, md);
      e.dp_a  = (sa == 1) && colon;
      e.dig_b = ~en_val(sb, bk);
      e.d_b   = digit_val(sb, md);
      e.dp_b  = (sb == 1) && colon;
      e.pm    = hh >= 12;
      cyc++;
      if (sm || sh) begin
        if (sm) mm = (mm + 1) % 60;
        if (sh) hh = (hh + 1) % 24;
      end else if (t) begin
        tot = (hh * 60 + mm + 1) % 1440;
        hh = tot / 60;
        mm = tot % 60;
        colon = !colon;
      end
    end
    e.tm = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
    q.push_back(e);
  endtask

  task automatic idle(int n, bit md, bit bk);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, md, bk);
  endtask

  task automatic preload(int h, int m);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < h; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < m; i++) step(0, 0, 1, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("digit_a", 16'(dig_a), 16'(e.dig_a));
        chk("d_a", 16'(d_a), 16'(e.d_a));
        chk("dp_a", 16'(dp_a), 16'(e.dp_a));
        chk("pm_a", 16'(pm_a), 16'(e.pm));
        chk("time_a", {2'b0, hour10_a, hour1_a, 1'b0, min10_a, min1_a}, e.tm);
        chk("digit_b", 16'(dig_b), 16'(e.dig_b));
        chk("d_b", 16'(d_b), 16'(e.d_b));
        chk("dp_b", 16'(dp_b), 16'(e.dp_b));
        chk("pm_b", 16'(pm_b), 16'(e.pm));
        chk("time_b", {2'b0, hour10_b, hour1_b, 1'b0, min10_b, min1_b}, e.tm);
      end
    end
  end

  initial begin : stim
    Reset = 1'b1; Tick = 1'b0; SyncMinIn = 1'b0; SyncHourIn = 1'b0;
    Mode12 = 1'b0; Blank = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(20, 0, 0);

    preload(23, 59);
    step(0, 1, 0, 0, 0, 0);
    idle(16, 0, 0);

    preload(9, 59);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    idle(12, 0, 0);

    preload(13, 5);
    idle(16, 1, 0);
    preload(0, 30);
    idle(16, 1, 0);

    idle(6, 0, 0);
    idle(9, 0, 1);
    idle(12, 0, 0);

    idle(5, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(2, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(10, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) m12 = ~m12;
      if ($urandom_range(9) == 0) bl = ~bl;
      step($urandom_range(299) == 0, $urandom_range(2) == 0,
           $urandom_range(7) == 0, $urandom_range(9) == 0, m12, bl);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drain", 16'(q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
